// File: rtl/vga_osd_pkg.sv
// Shared constants, state encoding and helpers for the OSD fill controller.
// Holds the default raster geometry and the address/coordinate widths.
package vga_osd_pkg;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StFill,
    StDone
  } state_e;

  // y*k built from shifted copies of the constant k, so the row-base load needs only adders.
  function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0] y, input int unsigned k);
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] step;
    acc  = '0;
    step = ADDR_W'(k);
    for (int i = 0; i < int'(Y_W); i++) begin
      if (y[i]) acc = acc + step;
      step = step << 1;
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_osd_addr_gen.sv
// Raster-order address walker: x/y counters, row base and last-pixel flag.
// addr_o is itself a register, advanced by +1 along a line and by one row stride per line.
module vga_osd_addr_gen
  import vga_osd_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [X_W-1:0]    x0_i,
  input  logic [X_W-1:0]    x1_i,
  input  logic [Y_W-1:0]    y0_i,
  input  logic [Y_W-1:0]    y1_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] HStep = ADDR_W'(H_RES);

  logic [X_W-1:0]    x_q, x_d, x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0]    y_q, y_d, y1_q, y1_d;
  logic [ADDR_W-1:0] row_q, row_d, addr_q, addr_d;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    x0_d   = x0_q;
    x1_d   = x1_q;
    y1_d   = y1_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (load_i) begin
      x_d    = x0_i;
      y_d    = y0_i;
      x0_d   = x0_i;
      x1_d   = x1_i;
      y1_d   = y1_i;
      row_d  = row_base(y0_i, H_RES);
      addr_d = row_base(y0_i, H_RES) + ADDR_W'(x0_i);
    end else if (step_i) begin
      if (x_q == x1_q) begin
        x_d    = x0_q;
        y_d    = y_q + Y_W'(1);
        row_d  = row_q + HStep;
        addr_d = row_q + HStep + ADDR_W'(x0_q);
      end else begin
        x_d    = x_q + X_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= '0;
      y_q    <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      y1_q   <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      x0_q   <= x0_d;
      x1_q   <= x1_d;
      y1_q   <= y1_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (x_q == x1_q) && (y_q == y1_q);

endmodule

// File: rtl/vga_osd_fill_ctrl.sv
// OSD RAM writer: rectangle fills and full-screen clears, one pixel per clock.
// Clear requests are latched and always win arbitration in IDLE.
module vga_osd_fill_ctrl
  import vga_osd_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic [X_W-1:0]    iCMD_X0,
  input  logic [X_W-1:0]    iCMD_X1,
  input  logic [Y_W-1:0]    iCMD_Y0,
  input  logic [Y_W-1:0]    iCMD_Y1,
  input  logic              iCMD_DATA,
  input  logic              iCLR_REQ,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic              oWR_DATA,
  output logic              oWR_EN,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR
);

  localparam logic [X_W-1:0] XMax = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] YMax = Y_W'(V_RES - 1);

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   clr_prev_q, rdy_en_q;
  logic   wr_en_q, wr_en_d, wr_data_q, wr_data_d, done_q, done_d, err_q, err_d;

  logic           clr_rise, clr_pend, accept, cmd_bad, start_clr, start_fill;
  logic           ag_load, ag_step, ag_clr, ag_last;
  logic [X_W-1:0] ag_x0, ag_x1;
  logic [Y_W-1:0] ag_y0, ag_y1;

  assign clr_rise = iCLR_REQ && !clr_prev_q;
  // A pulse arriving this cycle already counts as pending, so it blocks acceptance now.
  assign clr_pend = pend_q || clr_rise;
  assign oCMD_READY = rdy_en_q && (state_q == StIdle) && !clr_pend;
  assign accept = iCMD_VALID && oCMD_READY;
  assign cmd_bad = (iCMD_X0 > iCMD_X1) || (iCMD_Y0 > iCMD_Y1) ||
                   (iCMD_X0 > XMax) || (iCMD_Y0 > YMax);
  assign start_clr  = (state_q == StIdle) && clr_pend;
  assign start_fill = accept && !cmd_bad;

  assign ag_x0 = ag_clr ? '0 : iCMD_X0;
  assign ag_x1 = ag_clr ? XMax : ((iCMD_X1 > XMax) ? XMax : iCMD_X1);
  assign ag_y0 = ag_clr ? '0 : iCMD_Y0;
  assign ag_y1 = ag_clr ? YMax : ((iCMD_Y1 > YMax) ? YMax : iCMD_Y1);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_clr)       state_d = StClear;
        else if (start_fill) state_d = StFill;
      end
      StClear, StFill: if (ag_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    ag_load   = 1'b0;
    ag_step   = 1'b0;
    ag_clr    = 1'b0;
    pend_d    = clr_pend && !start_clr;
    unique case (state_q)
      StIdle: begin
        if (start_clr) begin
          ag_load   = 1'b1;
          ag_clr    = 1'b1;
          wr_en_d   = 1'b1;
          wr_data_d = 1'b0;
        end else if (accept) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            ag_load   = 1'b1;
            wr_en_d   = 1'b1;
            wr_data_d = iCMD_DATA;
          end
        end
      end
      StClear, StFill: begin
        if (ag_last) begin
          done_d = 1'b1;
        end else begin
          ag_step = 1'b1;
          wr_en_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pend_q     <= 1'b0;
      clr_prev_q <= 1'b0;
      rdy_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      clr_prev_q <= iCLR_REQ;
      rdy_en_q   <= 1'b1;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  vga_osd_addr_gen #(
    .H_RES (H_RES)
  ) u_addr_gen (
    .clk_i  (iCLK),
    .rst_ni (iRST_N),
    .load_i (ag_load),
    .step_i (ag_step),
    .x0_i   (ag_x0),
    .x1_i   (ag_x1),
    .y0_i   (ag_y0),
    .y1_i   (ag_y1),
    .addr_o (oWR_ADDR),
    .last_o (ag_last)
  );

  assign oWR_EN   = wr_en_q;
  assign oWR_DATA = wr_data_q;
  assign oDONE    = done_q;
  assign oERR     = err_q;
  assign oBUSY    = (state_q == StClear) || (state_q == StFill);

endmodule
